mult_accumulator: RTL and testbench



---
 rtl/mult_accumulator_if.sv | 24 ++
 rtl/mult_accumulator.sv | 104 ++++++++++
 tb/tb_mult_accumulator.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_accumulator_if.sv
// Product-in and result-out handshakes between the multiplier stage, the accumulator
// and the result consumer. The accumulator is the slave on both streams.
interface mult_accumulator_if #(
    parameter int PROD_WIDTH = 32,
    parameter int ACC_WIDTH  = 40
);
    logic                  in_valid;
    logic                  in_ready;
    logic [PROD_WIDTH-1:0] product;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_WIDTH-1:0]  result;
    logic                  overflow;

    modport master (
        output in_valid, product, out_ready,
        input  in_ready, out_valid, result, overflow
    );

    modport slave (
        input  in_valid, product, out_ready,
        output in_ready, out_valid, result, overflow
    );
endinterface

// File: rtl/mult_accumulator.sv
// Sums a programmed number of multiplier products into a wide wrap-around accumulator
// and presents the sum, with a sticky overflow flag, on a held output handshake.
module mult_accumulator #(
    parameter int INPUT_WIDTH = 16,
    parameter bit IS_SIGNED   = 1'b0,
    parameter int ACC_WIDTH   = 40,
    parameter int LEN_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    mult_accumulator_if.slave    bus,
    output logic                 busy
);
    localparam int PROD_WIDTH = INPUT_WIDTH * 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;

    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH:0]   sum_wide;
    logic                 ovf_add;
    logic                 accept;

    // Bits above the product width carry the product sign only for signed operation.
    for (genvar gi = 0; gi < ACC_WIDTH; gi++) begin : g_ext
        if (gi < PROD_WIDTH) begin : g_copy
            assign prod_ext[gi] = bus.product[gi];
        end else begin : g_fill
            assign prod_ext[gi] = IS_SIGNED ? bus.product[PROD_WIDTH-1] : 1'b0;
        end
    end

    assign sum_wide = {1'b0, acc_q} + {1'b0, prod_ext};
    assign ovf_add  = IS_SIGNED
                    ? ((acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                       (sum_wide[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]))
                    : sum_wide[ACC_WIDTH];

    assign accept = (state_q == ACCUM) && bus.in_valid;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = len;
                    state_d = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = sum_wide[ACC_WIDTH-1:0];
                    ovf_d = ovf_q | ovf_add;
                    cnt_d = cnt_q - LEN_WIDTH'(1);
                    if (cnt_q == LEN_WIDTH'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // The accumulator is only loaded on start, so result keeps the last sum through IDLE.
    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = acc_q;
    assign bus.overflow  = ovf_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_mult_accumulator.sv
// Drives an unsigned and a signed accumulator with identical randomized streams and
// compares both against an arithmetic model of each transaction.
module tb_mult_accumulator;
    localparam int IW = 8;
    localparam int PW = 16;
    localparam int UA = 16;
    localparam int SA = 18;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic          in_valid = 1'b0;
    logic [PW-1:0] product = '0;
    logic          out_ready = 1'b0;
    logic          busy_u, busy_s;

    int n_checks = 0;
    int n_errors = 0;
    int txn_id = 0;

    logic [PW-1:0] fixed_q[$];
    logic [PW-1:0] acc_list[$];

    mult_accumulator_if #(.PROD_WIDTH(PW), .ACC_WIDTH(UA)) ubus ();
    mult_accumulator_if #(.PROD_WIDTH(PW), .ACC_WIDTH(SA)) sbus ();

    assign ubus.in_valid  = in_valid;
    assign ubus.product   = product;
    assign ubus.out_ready = out_ready;
    assign sbus.in_valid  = in_valid;
    assign sbus.product   = product;
    assign sbus.out_ready = out_ready;

    mult_accumulator #(.INPUT_WIDTH(IW), .IS_SIGNED(1'b0), .ACC_WIDTH(UA), .LEN_WIDTH(LW)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .bus(ubus), .busy(busy_u)
    );
    mult_accumulator #(.INPUT_WIDTH(IW), .IS_SIGNED(1'b1), .ACC_WIDTH(SA), .LEN_WIDTH(LW)) s_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .bus(sbus), .busy(busy_s)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: true-sum arithmetic, wrapped to the accumulator range after every add.
    task automatic model(input logic [PW-1:0] p[$],
                         output logic [UA-1:0] ures, output logic uovf,
                         output logic [SA-1:0] sres, output logic sovf);
        longint us = 0;
        longint ss = 0;
        uovf = 1'b0;
        sovf = 1'b0;
        foreach (p[i]) begin
            us += longint'(p[i]);
            if (us >= 65536) begin
                us -= 65536;
                uovf = 1'b1;
            end
            ss += longint'($signed(p[i]));
            if (ss > 131071) begin
                ss -= 262144;
                sovf = 1'b1;
            end else if (ss < -131072) begin
                ss += 262144;
                sovf = 1'b1;
            end
        end
        ures = us[UA-1:0];
        sres = ss[SA-1:0];
    endtask

    function automatic logic [PW-1:0] rand_prod();
        case ($urandom_range(0, 3))
            0:       return 16'hFFFF - PW'($urandom_range(0, 255));
            1:       return 16'h8000 + PW'($urandom_range(0, 255));
            default: return PW'($urandom);
        endcase
    endfunction

    task automatic run_txn(input int n, input bit bubbles, input int hold, input bit reset_after2);
        logic [UA-1:0] eu;
        logic [SA-1:0] es;
        logic          euo, eso;
        logic          v;
        logic [PW-1:0] p;
        int            got;
        acc_list.delete();
        @(negedge clk);
        check("idle_busy", 64'({busy_u, busy_s}), 64'(2'b00));
        start = 1'b1;
        len   = n[LW-1:0];
        @(negedge clk);
        start = 1'b0;
        got   = 0;
        while (got < n) begin
            check("in_ready", 64'({ubus.in_ready, sbus.in_ready}), 64'(2'b11));
            if (reset_after2 && got == 2) begin
                rst_n = 1'b0;
                #1;
                check("rst_in_ready", 64'({ubus.in_ready, sbus.in_ready}), 64'(0));
                check("rst_busy", 64'({busy_u, busy_s}), 64'(0));
                check("rst_out_valid", 64'({ubus.out_valid, sbus.out_valid}), 64'(0));
                check("rst_result", 64'({ubus.result, sbus.result}), 64'(0));
                check("rst_overflow", 64'({ubus.overflow, sbus.overflow}), 64'(0));
                @(negedge clk);
                rst_n = 1'b1;
                $display("txn %0d: reset after %0d of %0d accepts", txn_id, got, n);
                txn_id++;
                return;
            end
            v = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bubbles) begin
                start = 1'($urandom_range(0, 1));
                len   = LW'($urandom);
            end
            p = '0;
            if (v) begin
                p = (fixed_q.size() != 0) ? fixed_q.pop_front() : rand_prod();
                acc_list.push_back(p);
            end
            in_valid = v;
            product  = v ? p : 'x;
            @(negedge clk);
            if (v) got++;
        end
        in_valid = 1'b0;
        product  = 'x;
        start    = 1'b0;
        model(acc_list, eu, euo, es, eso);
        for (int c = 0; c <= hold; c++) begin
            out_ready = (c == hold);
            check("out_valid", 64'({ubus.out_valid, sbus.out_valid}), 64'(2'b11));
            check("done_in_ready", 64'({ubus.in_ready, sbus.in_ready}), 64'(2'b00));
            check("u_result", 64'(ubus.result), 64'(eu));
            check("s_result", 64'(sbus.result), 64'(es));
            check("u_overflow", 64'(ubus.overflow), 64'(euo));
            check("s_overflow", 64'(sbus.overflow), 64'(eso));
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("post_out_valid", 64'({ubus.out_valid, sbus.out_valid}), 64'(2'b00));
        check("post_busy", 64'({busy_u, busy_s}), 64'(2'b00));
        check("post_u_result", 64'(ubus.result), 64'(eu));
        check("post_s_result", 64'(sbus.result), 64'(es));
        $display("txn %0d: len=%0d bubbles=%0d hold=%0d u=%0h/%0d s=%0h/%0d",
                 txn_id, n, bubbles, hold, eu, euo, es, eso);
        txn_id++;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_in_ready", 64'({ubus.in_ready, sbus.in_ready}), 64'(0));
        check("reset_out_valid", 64'({ubus.out_valid, sbus.out_valid}), 64'(0));
        check("reset_busy", 64'({busy_u, busy_s}), 64'(0));
        check("reset_result", 64'({ubus.result, sbus.result}), 64'(0));
        check("reset_overflow", 64'({ubus.overflow, sbus.overflow}), 64'(0));
        rst_n = 1'b1;

        fixed_q = '{16'd100, 16'd200, 16'd300, 16'd400};
        run_txn(4, 1'b0, 0, 1'b0);
        fixed_q = '{16'hFFF6, 16'h0005, 16'hFFFE};
        run_txn(3, 1'b0, 2, 1'b0);
        fixed_q = '{16'd11, 16'd22, 16'd33};
        run_txn(3, 1'b1, 5, 1'b0);
        fixed_q = '{16'hFFFF, 16'h0002};
        run_txn(2, 1'b0, 1, 1'b0);
        fixed_q = '{16'd1, 16'd2};
        run_txn(2, 1'b0, 0, 1'b0);
        fixed_q = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        run_txn(5, 1'b0, 0, 1'b0);
        fixed_q = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
        run_txn(5, 1'b1, 1, 1'b0);
        run_txn(0, 1'b0, 1, 1'b0);
        fixed_q = '{16'd50, 16'd60, 16'd70, 16'd80};
        run_txn(4, 1'b0, 0, 1'b1);
        fixed_q.delete();
        fixed_q = '{16'd7};
        run_txn(1, 1'b0, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            run_txn($urandom_range(0, 24), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
